// File: rtl/fft4_sched_pkg.sv
// Shared types, constants and width helpers for the radix-4 twiddle-stage scheduler.
package fft4_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   localparam int PIPE_LAT_DEF  = 6;
   // Sample-buffer read (1 clk) plus datapath latency.
   localparam int RD_TO_RES_LAT = PIPE_LAT_DEF + 1;

   // One extra bit so a full frame of 2^label_width labels does not wrap.
   function automatic int cnt_width(input int label_width);
      return label_width + 1;
   endfunction

   function automatic int credit_width(input int credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/fft4_credit_counter.sv
// Saturating up/down credit counter guarding the non-stallable datapath's result FIFO.
module fft4_credit_counter
   import fft4_sched_pkg::*;
#(
   parameter int CREDITS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic take,
   input  logic give,
   output logic has_credit
);

   localparam int CW = credit_width(CREDITS);
   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   logic [CW-1:0] credit_q, credit_d;

   // Take and give together cancel; a give with the counter full is dropped.
   always_comb begin
      credit_d = credit_q;
      if (take && !give && (credit_q != '0)) begin
         credit_d = credit_q - CW'(1);
      end else if (give && !take && (credit_q != FULL)) begin
         credit_d = credit_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= FULL;
      end else begin
         credit_q <= credit_d;
      end
   end

   assign has_credit = (credit_q != '0);

endmodule

// File: rtl/fft4_twiddle_scheduler.sv
// Issues one sample-buffer read per group label and tracks datapath results with credits.
// Define FFT4_SCHED_ORDER_CHECK_EN to enable the result label-order checker (order_err).
module fft4_twiddle_scheduler
   import fft4_sched_pkg::*;
#(
   parameter int LABEL_WIDTH = 11,
   parameter int NUM_GROUPS  = 2048,
   parameter int PIPE_LAT    = 6,
   parameter int CREDITS     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   src_avail,
   output logic                   rd_en,
   output logic [LABEL_WIDTH-1:0] rd_addr,
   output logic                   dp_valid,
   output logic [LABEL_WIDTH-1:0] dp_lable,
   input  logic                   dp_ready,
   input  logic [LABEL_WIDTH-1:0] dp_index,
   input  logic                   res_pop,
   output logic                   busy,
   output logic                   done,
   output logic                   order_err,
   output logic [1:0]             dbg_state
);

   localparam int CW = cnt_width(LABEL_WIDTH);
   localparam logic [CW-1:0] LAST_LABEL = CW'(NUM_GROUPS - 1);
   localparam logic [CW-1:0] TOTAL      = CW'(NUM_GROUPS);
   // Correctness never depends on the datapath latency; kept for reference only.
   localparam int res_lat_unused = PIPE_LAT + 1;

   sched_state_e state_q, state_d;
   logic [CW-1:0] issue_cnt_q, issue_cnt_d;
   logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
   logic [LABEL_WIDTH-1:0] dp_lable_q;
   logic dp_valid_q;
   logic has_credit;
   logic in_frame;
   logic issue;
   logic rsp_hit;
   logic frame_done;

   assign in_frame = (state_q != IDLE);
   assign issue    = (state_q == ISSUE) && src_avail && has_credit;
   assign rsp_hit  = dp_ready && in_frame;

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      rsp_cnt_d   = rsp_cnt_q + CW'(rsp_hit);
      frame_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ISSUE;
               issue_cnt_d = '0;
               rsp_cnt_d   = '0;
            end
         end
         ISSUE: begin
            if (issue) begin
               issue_cnt_d = issue_cnt_q + CW'(1);
               if (issue_cnt_q == LAST_LABEL) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Close the frame in the cycle the final result arrives.
            if (rsp_cnt_d >= TOTAL) begin
               state_d    = IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         rsp_cnt_q   <= '0;
         dp_valid_q  <= 1'b0;
         dp_lable_q  <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         rsp_cnt_q   <= rsp_cnt_d;
         dp_valid_q  <= issue;
         dp_lable_q  <= rd_addr;
      end
   end

   fft4_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk        (clk),
      .rst_n      (rst_n),
      .take       (issue),
      .give       (res_pop),
      .has_credit (has_credit)
   );

   assign rd_en     = issue;
   assign rd_addr   = issue_cnt_q[LABEL_WIDTH-1:0];
   assign dp_valid  = dp_valid_q;
   assign dp_lable  = dp_lable_q;
   assign busy      = in_frame && !frame_done;
   assign done      = frame_done;
   assign dbg_state = state_q;

`ifdef FFT4_SCHED_ORDER_CHECK_EN
   logic order_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         order_err_q <= 1'b0;
      end else if ((state_q == IDLE) && start) begin
         order_err_q <= 1'b0;
      end else if (rsp_hit && (dp_index != rsp_cnt_q[LABEL_WIDTH-1:0])) begin
         order_err_q <= 1'b1;
      end
   end

   assign order_err = order_err_q;
`else
   logic idx_unused;

   assign idx_unused = ^dp_index;
   assign order_err  = 1'b0;
`endif

endmodule
